// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read per cycle and
// queues {instr, pc} pairs for decode; a redirect flushes everything in flight.
module fetch_unit #(
    parameter int                      ADDRESS_SIZE  = 32,
    parameter int                      DATA_SIZE     = 32,
    parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = 32'h80020000,
    parameter logic [DATA_SIZE-1:0]    NOP           = 32'h00000000,
    parameter int                      FIFO_DEPTH    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic                    mem_enable,
    output logic                    mem_wren,
    output logic [1:0]              mem_acc_size,
    output logic                    mem_byteOnly,
    input  logic [DATA_SIZE-1:0]    mem_d_out,
    input  logic                    mem_busy,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_SIZE-1:0] redirect_pc,
    output logic                    if_valid,
    input  logic                    if_ready,
    output logic [DATA_SIZE-1:0]    if_instr,
    output logic [ADDRESS_SIZE-1:0] if_pc
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_L = OCC_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_SIZE-1:0]    instr;
        logic [ADDRESS_SIZE-1:0] pc;
    } entry_t;

    logic [ADDRESS_SIZE-1:0] pc;
    logic [ADDRESS_SIZE-1:0] pend_pc;
    logic                    pending;
    logic [CNT_W-1:0]        count;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    entry_t                  fifo [FIFO_DEPTH];

    logic             pop;
    logic             push;
    logic             issue;
    logic [OCC_W-1:0] occ;

    // Occupancy counts the in-flight word so a pending response always has a slot.
    always_comb begin
        pop   = if_valid & if_ready & ~redirect_valid;
        push  = pending & ~redirect_valid;
        occ   = OCC_W'(count) + OCC_W'(pending) - OCC_W'(pop);
        issue = rst_n & ~redirect_valid & ~mem_busy & (occ < DEPTH_L);
    end

    assign mem_enable   = issue;
    assign mem_addr     = pc;
    assign mem_wren     = 1'b0;
    assign mem_acc_size = 2'b00;
    assign mem_byteOnly = 1'b0;

    assign if_valid = (count != '0);
    assign if_instr = if_valid ? fifo[rd_ptr].instr : NOP;
    assign if_pc    = if_valid ? fifo[rd_ptr].pc    : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= START_ADDRESS;
            pend_pc <= '0;
            pending <= 1'b0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else if (redirect_valid) begin
            pc      <= redirect_pc & ~ADDRESS_SIZE'(3);
            pending <= 1'b0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            pending <= issue;
            if (issue) begin
                pc      <= pc + ADDRESS_SIZE'(4);
                pend_pc <= pc;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: entries are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= '{instr: mem_d_out, pc: pend_pc};
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural memory answers reads, stimulus
// pushes expected {pc, instr} pairs and a monitor compares every accepted head.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] mem_addr;
    logic        mem_enable;
    logic        mem_wren;
    logic [1:0]  mem_acc_size;
    logic        mem_byteOnly;
    logic [31:0] mem_d_out = 32'h0;
    logic        mem_busy = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q [$];

    localparam logic [31:0] BASE = 32'h80020000;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_enable(mem_enable),
        .mem_wren(mem_wren), .mem_acc_size(mem_acc_size), .mem_byteOnly(mem_byteOnly),
        .mem_d_out(mem_d_out), .mem_busy(mem_busy), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h80020000: mem_word = 32'h11;
            32'h80020004: mem_word = 32'h22;
            32'h80020008: mem_word = 32'h33;
            default:      mem_word = 32'hA5000000 | {8'h00, a[23:0]};
        endcase
    endfunction

    // One-cycle read latency; data holds (stale) when nothing is issued.
    always @(posedge clk) if (mem_enable && !mem_busy) mem_d_out <= mem_word(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_run(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({first + 32'(4 * i), mem_word(first + 32'(4 * i))});
    endtask

    always @(negedge clk) begin
        if (rst_n && if_valid && if_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop_pc", if_pc, 32'hxxxxxxxx);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("pop_pc", if_pc, e[63:32]);
                chk("pop_instr", if_instr, e[31:0]);
            end
        end
    end

    // Phase-2 hand-derived issue schedule (cycle index after reset release).
    function automatic logic exp_en(input int c);
        exp_en = !((c >= 5 && c <= 9) || (c >= 14 && c <= 16) || c == 21);
    endfunction

    function automatic logic [31:0] exp_addr(input int c);
        if (c <= 4)       exp_addr = BASE + 32'(4 * c);
        else if (c <= 13) exp_addr = BASE + 32'(4 * (c - 5));
        else if (c <= 20) exp_addr = BASE + 32'(4 * (c - 8));
        else              exp_addr = BASE + 32'h100 + 32'(4 * (c - 22));
    endfunction

    initial begin
        #2 rst_n = 1'b0;
        if_ready = 1'b1;
        #1;
        chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_mem_enable", {31'b0, mem_enable}, 32'h0);
        chk("rst_mem_addr", mem_addr, BASE);
        chk("tied_outputs", {28'b0, mem_wren, mem_acc_size, mem_byteOnly}, 32'h0);

        // Phase 1: stream, then async reset while mem_addr = 0x80020010.
        @(posedge clk); #1 rst_n = 1'b1;
        expect_run(BASE, 3);
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            chk("p1_mem_enable", {31'b0, mem_enable}, 32'h1);
            chk("p1_mem_addr", mem_addr, BASE + 32'(4 * c));
            if (c < 2) chk("p1_if_valid_latency", {31'b0, if_valid}, 32'h0);
            if (c < 4) begin @(posedge clk); #1; end
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("midrst_if_pc", if_pc, 32'h0);
        chk("midrst_mem_enable", {31'b0, mem_enable}, 32'h0);
        chk("midrst_mem_addr", mem_addr, BASE);
        chk("p1_queue_drained", 32'(exp_q.size()), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Phase 2: stream, backpressure, mem_busy, redirect with a fetch in flight.
        expect_run(BASE, 11);
        redirect_pc = 32'h80020103;
        for (int c = 0; c <= 26; c++) begin
            if_ready       = !(c >= 5 && c <= 9) && (c < 26);
            mem_busy       = (c >= 14 && c <= 16);
            redirect_valid = (c == 21);
            if (c == 22) expect_run(BASE + 32'h100, 2);
            @(negedge clk);
            if (c <= 25) begin
                chk("p2_mem_enable", {31'b0, mem_enable}, {31'b0, exp_en(c)});
                if (exp_en(c)) chk("p2_mem_addr", mem_addr, exp_addr(c));
            end
            case (c)
                1:  chk("p2_if_valid_c1", {31'b0, if_valid}, 32'h0);
                2:  chk("p2_if_valid_c2", {31'b0, if_valid}, 32'h1);
                9:  begin
                        chk("bp_head_valid", {31'b0, if_valid}, 32'h1);
                        chk("bp_head_pc", if_pc, BASE + 32'hC);
                    end
                16: chk("busy_drained", {31'b0, if_valid}, 32'h0);
                21: chk("redir_head_visible", {31'b0, if_valid}, 32'h1);
                22: begin
                        chk("redir_flushed", {31'b0, if_valid}, 32'h0);
                        chk("redir_if_instr_nop", if_instr, 32'h0);
                    end
                23: chk("redir_if_valid_c23", {31'b0, if_valid}, 32'h0);
                24: chk("redir_first_pc", if_pc, BASE + 32'h100);
                default: ;
            endcase
            @(posedge clk); #1;
        end
        redirect_valid = 1'b0;
        chk("final_queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
